// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode/issue types: decoded control bundle, memory/CSR command
// encodings and the issue controller state encoding.
package decode_issue_ctrl_pkg;

    // Memory command encodings (subset used by the issue logic)
    localparam logic [4:0] M_XRD = 5'b00000;  // integer load
    localparam logic [4:0] M_XWR = 5'b00001;  // integer store

    // CSR command encodings; anything other than CSR_N is a CSR access
    localparam logic [2:0] CSR_N = 3'd0;

    // Decoded control signals for the instruction sitting in decode
    typedef struct packed {
        logic       legal;    // instruction decoded as legal
        logic       fence;    // FENCE
        logic       fence_i;  // FENCE.I
        logic [2:0] csr;      // CSR command
        logic       mem;      // memory access
        logic [4:0] mem_cmd;  // memory command
        logic       div;      // divide/remainder
        logic       wxd;      // writes integer rd
        logic       rxs1;     // reads integer rs1
        logic       rxs2;     // reads integer rs2
    } ControlSignals;

    // Issue controller states
    typedef enum logic [2:0] {
        RUN        = 3'd0,
        DRAIN      = 3'd1,
        FLUSH_REQ  = 3'd2,
        FLUSH_WAIT = 3'd3,
        ISSUE_SER  = 3'd4
    } IssueState;

    // Result arrives late (load or divide) and must be tracked in the scoreboard
    function automatic logic is_long_latency(input ControlSignals cs);
        return (cs.mem && (cs.mem_cmd == M_XRD)) || cs.div;
    endfunction

    // Instruction must run alone with the pipeline drained
    function automatic logic is_serialising(input ControlSignals cs);
        return cs.fence || cs.fence_i || (cs.csr != CSR_N);
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register, set when a
// long-latency producer issues and cleared by its writeback. x0 never pends.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic [AW-1:0] i_rs2_addr,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rs1_pend,
    output logic          o_rs2_pend,
    output logic          o_rd_pend,
    output logic          o_any_pend
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // Next pending vector: clear first, then set, so a same-cycle set wins
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_addr] = 1'b1;
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    // Pending vector register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this is control state, not data storage, so every bit is reset; a stale bit would stall forever.
        if (!rst_n) r_pending <= '0;
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        else        r_pending <= w_pending_nxt;
    end

    // Read ports see only the registered vector
    assign o_rs1_pend = r_pending[i_rs1_addr];
    assign o_rs2_pend = r_pending[i_rs2_addr];
    assign o_rd_pend  = r_pending[i_rd_addr];
    assign o_any_pend = |r_pending;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue controller: RAW/WAW stalls against long-latency
// writebacks, memory back-pressure, FENCE/CSR drain and FENCE.I flush sequencing.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int MAX_MEM_OUTSTANDING = 4,
    parameter int NUM_REGS            = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic          id_kill,
    input  ControlSignals id_cs,
    input  logic [4:0]    id_rs1_addr,
    input  logic [4:0]    id_rs2_addr,
    input  logic [4:0]    id_rd_addr,
    input  logic          ex_ready,
    output logic          issue_valid,
    output logic          id_stall,
    input  logic          lw_wb_valid,
    input  logic [4:0]    lw_wb_addr,
    input  logic          mem_resp_valid,
    output logic          icache_flush_req,
    input  logic          icache_flush_done
);

    localparam int CNT_W = $clog2(MAX_MEM_OUTSTANDING + 1);

    IssueState        r_state;
    IssueState        w_state_nxt;
    logic             r_kill_seen;
    logic             w_kill_seen_nxt;
    logic [CNT_W-1:0] r_mem_cnt;

    logic w_rs1_pend;
    logic w_rs2_pend;
    logic w_rd_pend;
    logic w_any_pend;
    logic w_live;
    logic w_hazard;
    logic w_offer;
    logic w_fire;
    logic w_sb_set;
    logic w_mem_inc;
    logic w_drained;

    issue_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (5)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_sb_set),
        .i_set_addr (id_rd_addr),
        .i_clr_en   (lw_wb_valid),
        .i_clr_addr (lw_wb_addr),
        .i_rs1_addr (id_rs1_addr),
        .i_rs2_addr (id_rs2_addr),
        .i_rd_addr  (id_rd_addr),
        .o_rs1_pend (w_rs1_pend),
        .o_rs2_pend (w_rs2_pend),
        .o_rd_pend  (w_rd_pend),
        .o_any_pend (w_any_pend)
    );

    assign w_live    = id_valid && !id_kill;
    assign w_hazard  = (id_cs.rxs1 && w_rs1_pend) ||
                       (id_cs.rxs2 && w_rs2_pend) ||
                       (id_cs.wxd  && w_rd_pend)  ||
                       (id_cs.mem  && (r_mem_cnt == CNT_W'(MAX_MEM_OUTSTANDING)));
    assign w_drained = (r_mem_cnt == '0) && !w_any_pend;

    // Offer the decode instruction to execute when the state allows it
    always_comb begin
        w_offer = 1'b0;
        case (r_state)
            RUN:       w_offer = w_live && !w_hazard && !is_serialising(id_cs);
            ISSUE_SER: w_offer = w_live;
            default:   w_offer = 1'b0;
        endcase
    end

    // Outputs are forced low while reset is asserted
    assign issue_valid      = rst_n && w_offer;
    assign w_fire           = issue_valid && ex_ready;
    assign id_stall         = rst_n && w_live && !w_fire;
    assign icache_flush_req = rst_n && ((r_state == FLUSH_REQ) || (r_state == FLUSH_WAIT));

    // Illegal instructions issue without touching the scoreboard or counter
    assign w_sb_set  = w_fire && id_cs.legal && is_long_latency(id_cs) && id_cs.wxd;
    assign w_mem_inc = w_fire && id_cs.legal && id_cs.mem;

    // Outstanding memory op counter: issue increments, response decrements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_cnt <= '0;
        end else if (w_mem_inc && !mem_resp_valid) begin
            r_mem_cnt <= r_mem_cnt + CNT_W'(1);
        end else if (!w_mem_inc && mem_resp_valid && (r_mem_cnt != '0)) begin
            r_mem_cnt <= r_mem_cnt - CNT_W'(1);
        end
    end

    // A response with nothing outstanding is a protocol error upstream
    mem_resp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_resp_valid && !w_mem_inc && (r_mem_cnt == '0)));

    // Serialisation / flush FSM next-state
    always_comb begin
        w_state_nxt     = r_state;
        w_kill_seen_nxt = r_kill_seen;
        case (r_state)
            RUN: begin
                if (w_live && is_serialising(id_cs)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (id_kill)        w_state_nxt = RUN;
                else if (w_drained) w_state_nxt = id_cs.fence_i ? FLUSH_REQ : ISSUE_SER;
            end
            FLUSH_REQ: begin
                w_state_nxt     = FLUSH_WAIT;
                w_kill_seen_nxt = r_kill_seen || id_kill;
            end
            FLUSH_WAIT: begin
                // A kill cannot abort the flush; it only suppresses the issue afterwards
                if (icache_flush_done) begin
                    w_state_nxt     = (r_kill_seen || id_kill) ? RUN : ISSUE_SER;
                    w_kill_seen_nxt = 1'b0;
                end else begin
                    w_kill_seen_nxt = r_kill_seen || id_kill;
                end
            end
            ISSUE_SER: begin
                if (id_kill || w_fire) w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt     = RUN;
                w_kill_seen_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_kill_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_kill_seen <= w_kill_seen_nxt;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl.
module tb_decode_issue_ctrl;
    import decode_issue_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic          id_kill = 1'b0;
    ControlSignals id_cs = '0;
    logic [4:0]    id_rs1_addr = '0;
    logic [4:0]    id_rs2_addr = '0;
    logic [4:0]    id_rd_addr = '0;
    logic          ex_ready = 1'b1;
    logic          issue_valid;
    logic          id_stall;
    logic          lw_wb_valid = 1'b0;
    logic [4:0]    lw_wb_addr = '0;
    logic          mem_resp_valid = 1'b0;
    logic          icache_flush_req;
    logic          icache_flush_done = 1'b0;

    int checks = 0;
    int errors = 0;

    decode_issue_ctrl #(
        .MAX_MEM_OUTSTANDING (4),
        .NUM_REGS            (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_valid          (id_valid),
        .id_kill           (id_kill),
        .id_cs             (id_cs),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .id_rd_addr        (id_rd_addr),
        .ex_ready          (ex_ready),
        .issue_valid       (issue_valid),
        .id_stall          (id_stall),
        .lw_wb_valid       (lw_wb_valid),
        .lw_wb_addr        (lw_wb_addr),
        .mem_resp_valid    (mem_resp_valid),
        .icache_flush_req  (icache_flush_req),
        .icache_flush_done (icache_flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic ControlSignals cs_alu();
        ControlSignals c = '0;
        c.legal = 1'b1; c.wxd = 1'b1; c.rxs1 = 1'b1; c.rxs2 = 1'b1;
        return c;
    endfunction

    function automatic ControlSignals cs_load();
        ControlSignals c = '0;
        c.legal = 1'b1; c.mem = 1'b1; c.mem_cmd = M_XRD; c.wxd = 1'b1; c.rxs1 = 1'b1;
        return c;
    endfunction

    function automatic ControlSignals cs_store();
        ControlSignals c = '0;
        c.legal = 1'b1; c.mem = 1'b1; c.mem_cmd = M_XWR; c.rxs1 = 1'b1; c.rxs2 = 1'b1;
        return c;
    endfunction

    function automatic ControlSignals cs_fence(input logic fi);
        ControlSignals c = '0;
        c.legal = 1'b1; c.fence = !fi; c.fence_i = fi;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ControlSignals c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid = 1'b1; id_cs = c;
        id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_cs = '0;
        id_rd_addr = '0; id_rs1_addr = '0; id_rs2_addr = '0;
        #1;
    endtask

    task automatic mem_resp(input int n);
        idle();
        mem_resp_valid = 1'b1;
        for (int i = 0; i < n; i++) tick();
        mem_resp_valid = 1'b0;
        #1;
    endtask

    int delays [2] = '{1, 10};
    ControlSignals c_bad;

    initial begin
        // Reset holds outputs low even with a live instruction in decode
        drive(cs_alu(), 5'd1, 5'd2, 5'd3);
        check("rst_issue", issue_valid, 0);
        check("rst_stall", id_stall, 0);
        check("rst_flush", icache_flush_req, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("run_add_issue", issue_valid, 1);
        check("rst_state", dut.r_state, RUN);
        id_kill = 1'b1; #1;
        check("kill_issue", issue_valid, 0);
        check("kill_stall", id_stall, 0);
        id_kill = 1'b0; #1;

        // Illegal load: issues, no scoreboard or counter effect
        c_bad = cs_load();
        c_bad.legal = 1'b0;
        drive(c_bad, 5'd7, 5'd1, 5'd0);
        check("ill_issue", issue_valid, 1);
        tick();
        check("ill_pend", dut.u_sb.r_pending, 32'h0);
        check("ill_cnt", dut.r_mem_cnt, 0);

        // LW x5, held one cycle by ex_ready low
        drive(cs_load(), 5'd5, 5'd1, 5'd0);
        ex_ready = 1'b0; #1;
        check("lw_hold_issue", issue_valid, 1);
        check("lw_hold_stall", id_stall, 1);
        tick();
        check("lw_hold_pend", dut.u_sb.r_pending, 32'h0);
        ex_ready = 1'b1; #1;
        tick();
        check("lw_pend", dut.u_sb.r_pending, 32'h20);
        check("lw_cnt", dut.r_mem_cnt, 1);

        // ADD x6,x5,x1 waits for the x5 writeback
        drive(cs_alu(), 5'd6, 5'd5, 5'd1);
        check("raw_issue", issue_valid, 0);
        check("raw_stall", id_stall, 1);
        tick();
        lw_wb_valid = 1'b1; lw_wb_addr = 5'd5; #1;
        check("raw_wb_same_cycle", issue_valid, 0);
        tick();
        lw_wb_valid = 1'b0; #1;
        check("raw_pend_clear", dut.u_sb.r_pending, 32'h0);
        check("raw_issue_after", issue_valid, 1);
        tick();
        mem_resp(1);
        check("raw_cnt", dut.r_mem_cnt, 0);

        // LW x0 never pends
        drive(cs_load(), 5'd0, 5'd1, 5'd0);
        tick();
        check("x0_pend", dut.u_sb.r_pending, 32'h0);
        drive(cs_alu(), 5'd1, 5'd0, 5'd0);
        check("x0_add_issue", issue_valid, 1);
        check("x0_add_stall", id_stall, 0);
        tick();
        mem_resp(1);

        // Four stores fill the memory queue, the fifth stalls
        drive(cs_store(), 5'd0, 5'd1, 5'd2);
        for (int i = 0; i < 4; i++) begin
            check("sw_issue", issue_valid, 1);
            tick();
        end
        check("sw_cnt_full", dut.r_mem_cnt, 4);
        check("sw5_issue", issue_valid, 0);
        check("sw5_stall", id_stall, 1);
        drive(cs_alu(), 5'd3, 5'd1, 5'd2);
        mem_resp_valid = 1'b1; #1;
        check("resp_add_issue", issue_valid, 1);
        tick();
        mem_resp_valid = 1'b0;
        check("resp_add_cnt", dut.r_mem_cnt, 3);
        drive(cs_store(), 5'd0, 5'd1, 5'd2);
        mem_resp_valid = 1'b1; #1;
        check("resp_sw_issue", issue_valid, 1);
        tick();
        mem_resp_valid = 1'b0;
        check("resp_sw_cnt", dut.r_mem_cnt, 3);
        mem_resp(1);
        check("pre_fence_cnt", dut.r_mem_cnt, 2);

        // FENCE drains two outstanding ops, then issues alone
        drive(cs_fence(1'b0), 5'd0, 5'd0, 5'd0);
        check("fence_run_issue", issue_valid, 0);
        check("fence_run_stall", id_stall, 1);
        tick();
        check("fence_drain", dut.r_state, DRAIN);
        check("fence_drain_issue", issue_valid, 0);
        mem_resp_valid = 1'b1;
        tick();
        tick();
        mem_resp_valid = 1'b0; #1;
        check("fence_still_drain", dut.r_state, DRAIN);
        check("fence_cnt0", dut.r_mem_cnt, 0);
        tick();
        check("fence_ser", dut.r_state, ISSUE_SER);
        check("fence_ser_issue", issue_valid, 1);
        tick();
        check("fence_back_run", dut.r_state, RUN);
        check("fence_end_cnt", dut.r_mem_cnt, 0);
        idle();

        // FENCE.I with short and long flush latency
        for (int d = 0; d < 2; d++) begin
            drive(cs_fence(1'b1), 5'd0, 5'd0, 5'd0);
            check("fi_run_flush", icache_flush_req, 0);
            tick();
            check("fi_drain_flush", icache_flush_req, 0);
            tick();
            check("fi_req_state", dut.r_state, FLUSH_REQ);
            check("fi_req_flush", icache_flush_req, 1);
            tick();
            for (int k = 1; k < delays[d]; k++) begin
                check("fi_wait_flush", icache_flush_req, 1);
                check("fi_wait_issue", issue_valid, 0);
                tick();
            end
            icache_flush_done = 1'b1; #1;
            check("fi_done_flush", icache_flush_req, 1);
            tick();
            icache_flush_done = 1'b0; #1;
            check("fi_after_flush", icache_flush_req, 0);
            check("fi_after_state", dut.r_state, ISSUE_SER);
            check("fi_after_issue", issue_valid, 1);
            tick();
            check("fi_end_state", dut.r_state, RUN);
            idle();
        end

        // Kill during FLUSH_WAIT: flush completes, fence.i never issues
        drive(cs_fence(1'b1), 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        tick();
        id_kill = 1'b1; #1;
        check("fik_issue", issue_valid, 0);
        check("fik_stall", id_stall, 0);
        check("fik_flush", icache_flush_req, 1);
        tick();
        id_kill = 1'b0;
        drive(cs_alu(), 5'd1, 5'd2, 5'd3);
        check("fik_wait_flush", icache_flush_req, 1);
        check("fik_wait_issue", issue_valid, 0);
        check("fik_wait_stall", id_stall, 1);
        tick();
        icache_flush_done = 1'b1; #1;
        tick();
        icache_flush_done = 1'b0; #1;
        check("fik_state", dut.r_state, RUN);
        check("fik_flush_low", icache_flush_req, 0);
        check("fik_add_issue", issue_valid, 1);
        tick();
        idle();

        // Asynchronous reset in the middle of a drain
        drive(cs_load(), 5'd5, 5'd1, 5'd0);
        tick();
        drive(cs_store(), 5'd0, 5'd1, 5'd2);
        tick();
        tick();
        drive(cs_fence(1'b0), 5'd0, 5'd0, 5'd0);
        tick();
        check("mid_state", dut.r_state, DRAIN);
        check("mid_pend", dut.u_sb.r_pending, 32'h20);
        check("mid_cnt", dut.r_mem_cnt, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_state", dut.r_state, RUN);
        check("arst_pend", dut.u_sb.r_pending, 32'h0);
        check("arst_cnt", dut.r_mem_cnt, 0);
        check("arst_issue", issue_valid, 0);
        check("arst_stall", id_stall, 0);
        check("arst_flush", icache_flush_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
